// File: rtl/temp_fan_ctrl_pkg.sv
// Shared definitions for the over-temperature fan controller:
// FSM state encodings, default parameter values and counter sizing helper.
package temp_fan_ctrl_pkg;

    // FSM states, encoded to match the debug LED mapping
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ARM  = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } fan_state_e;

    localparam int unsigned DEF_DEBOUNCE_N   = 4;
    localparam int unsigned DEF_MIN_ON_TICKS = 8;
    localparam int unsigned DEF_ALARM_TICKS  = 32;
    localparam int unsigned DEF_PRESCALE     = 50000;

    // Upstream comparator threshold code (28 degrees), kept for cross-reference
    localparam logic [2:0] TEMP_THRESH_CODE = 3'b100;

    // Bits needed to hold a saturating count of 0..max_val
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/temp_fan_ctrl_tick_prescaler.sv
// Internal sample-tick generator: one-clk pulse every PRESCALE clk cycles.
// Only present when TEMP_FAN_TICK_GEN_EN is defined.
`ifdef TEMP_FAN_TICK_GEN_EN
module temp_fan_ctrl_tick_prescaler
    import temp_fan_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    output logic tick_c
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Modulo-PRESCALE count; the pulse marks the last count of each period
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_c = (cnt_q == CNT_LAST);
    end

    // Counter register, cleared by reset so the first pulse lands PRESCALE cycles later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/temp_fan_ctrl.sv
// Over-temperature fan controller: debounces the comparator flag on sample
// ticks, runs the fan with a minimum on-time and raises a sticky alarm when
// the over-temperature condition persists.
// Optional macro TEMP_FAN_TICK_GEN_EN: generate the sample tick internally
// from PRESCALE instead of using the tick port.
module temp_fan_ctrl
    import temp_fan_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N   = DEF_DEBOUNCE_N,
    parameter int unsigned MIN_ON_TICKS = DEF_MIN_ON_TICKS,
    parameter int unsigned ALARM_TICKS  = DEF_ALARM_TICKS,
    parameter int unsigned PRESCALE     = DEF_PRESCALE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       over_temp,
    input  logic       alarm_clr,
    output logic       fan_on,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int unsigned DEB_W = cnt_width(DEBOUNCE_N);
    localparam int unsigned ON_W  = cnt_width(MIN_ON_TICKS);
    localparam int unsigned HOT_W = cnt_width(ALARM_TICKS);

    localparam logic [DEB_W:0]   DEB_LIM   = (DEB_W + 1)'(DEBOUNCE_N);
    localparam logic [ON_W:0]    ON_LIM    = (ON_W + 1)'(MIN_ON_TICKS);
    localparam logic [HOT_W:0]   HOT_LIM   = (HOT_W + 1)'(ALARM_TICKS);
    localparam logic [ON_W-1:0]  ON_SAT    = ON_W'(MIN_ON_TICKS);
    localparam logic [HOT_W-1:0] HOT_SAT   = HOT_W'(ALARM_TICKS);

    fan_state_e       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
    logic [HOT_W-1:0] hot_cnt_q, hot_cnt_d;
    logic             fan_on_q, fan_on_d;
    logic             alarm_q, alarm_d;

    logic             tick_s;
    logic [DEB_W:0]   deb_inc;
    logic [ON_W:0]    on_inc;
    logic [HOT_W:0]   hot_inc;
    logic [ON_W-1:0]  on_sat;
    logic [HOT_W-1:0] hot_sat;
    logic             alarm_set;

`ifdef TEMP_FAN_TICK_GEN_EN
    logic unused_tick;
    assign unused_tick = tick;

    temp_fan_ctrl_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk    (clk),
        .reset  (reset),
        .tick_c (tick_s)
    );
`else
    localparam int unsigned unused_prescale = PRESCALE;
    assign tick_s = tick;
`endif

    // State, counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_OFF;
            deb_cnt_q <= '0;
            on_cnt_q  <= '0;
            hot_cnt_q <= '0;
            fan_on_q  <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            on_cnt_q  <= on_cnt_d;
            hot_cnt_q <= hot_cnt_d;
            fan_on_q  <= fan_on_d;
            alarm_q   <= alarm_d;
        end
    end

    // Next-state and counter updates, evaluated only on sample ticks
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        on_cnt_d  = on_cnt_q;
        hot_cnt_d = hot_cnt_q;
        deb_inc   = {1'b0, deb_cnt_q} + (DEB_W + 1)'(1);
        on_inc    = {1'b0, on_cnt_q} + (ON_W + 1)'(1);
        hot_inc   = {1'b0, hot_cnt_q} + (HOT_W + 1)'(1);
        on_sat    = (on_inc >= ON_LIM) ? ON_SAT : on_inc[ON_W-1:0];
        hot_sat   = (hot_inc >= HOT_LIM) ? HOT_SAT : hot_inc[HOT_W-1:0];

        if (tick_s) begin
            unique case (state_q)
                ST_OFF: begin
                    if (over_temp) begin
                        deb_cnt_d = DEB_W'(1);
                        if (DEB_LIM == (DEB_W + 1)'(1)) begin
                            state_d   = ST_ON;
                            on_cnt_d  = '0;
                            hot_cnt_d = HOT_W'(1);
                        end else begin
                            state_d = ST_ARM;
                        end
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                ST_ARM: begin
                    if (over_temp) begin
                        deb_cnt_d = deb_inc[DEB_W-1:0];
                        if (deb_inc == DEB_LIM) begin
                            state_d   = ST_ON;
                            on_cnt_d  = '0;
                            hot_cnt_d = HOT_W'(1);
                        end
                    end else begin
                        state_d   = ST_OFF;
                        deb_cnt_d = '0;
                    end
                end
                ST_ON: begin
                    on_cnt_d = on_sat;
                    if (over_temp) begin
                        hot_cnt_d = hot_sat;
                    end else begin
                        hot_cnt_d = '0;
                        if (on_inc >= ON_LIM) begin
                            state_d   = ST_OFF;
                            deb_cnt_d = '0;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    on_cnt_d = on_sat;
                    if (over_temp) begin
                        state_d   = ST_ON;
                        hot_cnt_d = HOT_W'(1);
                    end else begin
                        hot_cnt_d = '0;
                        if (on_inc >= ON_LIM) begin
                            state_d   = ST_OFF;
                            deb_cnt_d = '0;
                        end
                    end
                end
            endcase
        end
    end

    // Registered outputs: fan follows next state; alarm is sticky, set beats clear
    always_comb begin
        fan_on_d  = (state_d == ST_ON) || (state_d == ST_HOLD);
        alarm_set = tick_s && (state_d == ST_ON) && (hot_cnt_d == HOT_SAT);
        alarm_d   = alarm_q;
        if (alarm_clr) begin
            alarm_d = 1'b0;
        end
        if (alarm_set) begin
            alarm_d = 1'b1;
        end
    end

    assign fan_on = fan_on_q;
    assign alarm  = alarm_q;
    assign state  = state_q;

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// Scoreboard bench for temp_fan_ctrl: the driver pushes hand-computed
// expected outputs per cycle; the monitor pops and compares after each edge.
module tb_temp_fan_ctrl;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    typedef struct {
        logic [1:0] st;
        logic       fan;
        logic       alm;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       over_temp = 1'b0;
    logic       alarm_clr = 1'b0;
    logic       fan_on;
    logic       alarm;
    logic [1:0] state;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef TEMP_FAN_TICK_GEN_EN
    temp_fan_ctrl #(.PRESCALE(5)) dut (
`else
    temp_fan_ctrl dut (
`endif
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .over_temp (over_temp),
        .alarm_clr (alarm_clr),
        .fan_on    (fan_on),
        .alarm     (alarm),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Monitor: after each clock edge or reset assertion, check the next expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (state !== e.st || fan_on !== e.fan || alarm !== e.alm) begin
                    n_bad++;
                    $display("FAIL %s: got state=%0d fan_on=%0b alarm=%0b, expected state=%0d fan_on=%0b alarm=%0b",
                             e.nm, state, fan_on, alarm, e.st, e.fan, e.alm);
                end
            end
        end
    end

    task automatic expect_out(input logic [1:0] st, input logic fan, input logic alm, input string nm);
        exp_t e;
        e.st = st; e.fan = fan; e.alm = alm; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus plus the outputs expected after its rising edge
    task automatic step(input logic t, input logic ov, input logic clr,
                        input logic [1:0] st, input logic fan, input logic alm, input string nm);
        @(negedge clk);
        tick = t;
        over_temp = ov;
        alarm_clr = clr;
        expect_out(st, fan, alm, nm);
        @(posedge clk);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear at once and stay clear while held
    task automatic do_reset(input string nm);
        @(negedge clk);
        tick = 1'b0;
        over_temp = 1'b0;
        alarm_clr = 1'b0;
        expect_out(S_OFF, 1'b0, 1'b0, {nm, "_immediate"});
        #2 reset = 1'b1;
        @(negedge clk);
        expect_out(S_OFF, 1'b0, 1'b0, {nm, "_held"});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

`ifdef TEMP_FAN_TICK_GEN_EN
        // Internal tick every 5 clks; debounce of 4 completes on clk 20
        for (int c = 1; c <= 22; c++) begin
            step(1'b0, 1'b1, 1'b0,
                 (c < 5) ? S_OFF : ((c < 20) ? S_ARM : S_ON),
                 (c >= 20), 1'b0, $sformatf("tickgen_c%0d", c));
        end
`else
        step(1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, "reset_state");

        // Short over-temp burst aborts debounce; off-tick cycles are ignored
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "deb1");
        step(1'b0, 1'b0, 1'b0, S_ARM, 1'b0, 1'b0, "deb_no_tick");
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "deb2");
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "deb3");
        step(1'b1, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, "deb_abort");
        step(1'b0, 1'b1, 1'b0, S_OFF, 1'b0, 1'b0, "off_no_tick");

        // Full debounce, then short hot run and HOLD until minimum on-time
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "arm1");
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "arm2");
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "arm3");
        step(1'b1, 1'b1, 1'b0, S_ON,  1'b1, 1'b0, "fan_rise");
        step(1'b1, 1'b1, 1'b0, S_ON,  1'b1, 1'b0, "on1");
        step(1'b1, 1'b1, 1'b0, S_ON,  1'b1, 1'b0, "on2");
        step(1'b1, 1'b0, 1'b0, S_HOLD, 1'b1, 1'b0, "hold_on3");
        for (int k = 4; k <= 7; k++) begin
            step(1'b1, 1'b0, 1'b0, S_HOLD, 1'b1, 1'b0, $sformatf("hold_on%0d", k));
        end
        step(1'b0, 1'b0, 1'b0, S_HOLD, 1'b1, 1'b0, "hold_no_tick");
        step(1'b1, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, "hold_min_done");

        // Re-arm needs full debounce; HOLD->ON keeps on_cnt, then direct ON->OFF
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "rearm1");
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "rearm2");
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "rearm3");
        step(1'b1, 1'b1, 1'b0, S_ON,  1'b1, 1'b0, "rearm_on");
        step(1'b1, 1'b0, 1'b0, S_HOLD, 1'b1, 1'b0, "hold_on1");
        step(1'b1, 1'b1, 1'b0, S_ON,  1'b1, 1'b0, "hold_back_on2");
        for (int k = 3; k <= 7; k++) begin
            step(1'b1, 1'b1, 1'b0, S_ON, 1'b1, 1'b0, $sformatf("reon%0d", k));
        end
        step(1'b1, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, "direct_on_off");

        // 35 hot ticks: alarm sets when hot_cnt reaches 32, sticky through OFF
        for (int k = 1; k <= 35; k++) begin
            step(1'b1, 1'b1, 1'b0, (k < 4) ? S_ARM : S_ON, (k >= 4), (k == 35),
                 $sformatf("alarm_run%0d", k));
        end
        step(1'b1, 1'b1, 1'b0, S_ON,  1'b1, 1'b1, "alarm_hot");
        step(1'b1, 1'b0, 1'b0, S_OFF, 1'b0, 1'b1, "alarm_sticky_off");
        step(1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b1, "alarm_idle");
        step(1'b0, 1'b0, 1'b1, S_OFF, 1'b0, 1'b0, "alarm_clr");
        step(1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, "alarm_cleared");

        // Clear coincident with the set tick: set wins
        for (int k = 1; k <= 35; k++) begin
            step(1'b1, 1'b1, (k == 35), (k < 4) ? S_ARM : S_ON, (k >= 4), (k == 35),
                 $sformatf("coinc_run%0d", k));
        end
        step(1'b0, 1'b1, 1'b0, S_ON, 1'b1, 1'b1, "coinc_hold");

        // Reset mid-ON with alarm set, then idle until over-temp ticks resume
        do_reset("reset_mid_on");
        step(1'b0, 1'b1, 1'b0, S_OFF, 1'b0, 1'b0, "post_reset_no_tick");
        step(1'b1, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, "post_reset_cool");
        step(1'b1, 1'b1, 1'b0, S_ARM, 1'b0, 1'b0, "post_reset_arm");
`endif

        @(negedge clk);
        tick = 1'b0;
        over_temp = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
